cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter LINE_BITS, default 256, cacheline width in bits on all data buses.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_pmem_read  input  1  instruction-cache line-fill request.
REQ-005 i_pmem_address  input  32  instruction-cache line address.
REQ-006 i_pmem_rdata  output  LINE_BITS  fill data to instruction cache.
REQ-007 i_pmem_resp  output  1  instruction-cache transaction complete.
REQ-008 d_pmem_read  input  1  data-cache line-fill request.
REQ-009 d_pmem_write  input  1  data-cache write-back request.
REQ-010 d_pmem_address  input  32  data-cache line address.
REQ-011 d_pmem_wdata  input  LINE_BITS  data-cache write-back line.
REQ-012 d_pmem_rdata  output  LINE_BITS  fill data to data cache.
REQ-013 d_pmem_resp  output  1  data-cache transaction complete.
REQ-014 pmem_read / pmem_write  output  1 each  physical-memory command.
REQ-015 pmem_address  output  32  physical-memory line address.
REQ-016 pmem_wdata  output  LINE_BITS  physical-memory write line.
REQ-017 pmem_rdata  input  LINE_BITS  physical-memory read line.
REQ-018 pmem_resp  input  1  physical-memory transaction complete.

Function
REQ-019 FSM states SHALL be IDLE, SERVE_I, SERVE_D, GAP; exactly one transaction outstanding to physical memory at any time.
REQ-020 In IDLE with no request: stay IDLE, all pmem_* commands 0.
REQ-021 In IDLE with only I request: next state SERVE_I; with only D request (read or write): next state SERVE_D.
REQ-022 In IDLE with both requesting: grant D unless last_grant == D, then grant I (alternate on conflict; no starvation).
REQ-023 last_grant register SHALL update to the granted side on every IDLE->SERVE transition; reset value I.
REQ-024 On grant, address, direction (read/write) and wdata SHALL be latched; pmem_* outputs driven only from latched values in SERVE states, first asserted the cycle after the request is sampled in IDLE.
REQ-025 d_pmem_write and d_pmem_read both high: treat as write; read ignored for that grant.
REQ-026 In SERVE_x: hold pmem command/address/wdata stable until pmem_resp; on pmem_resp, next state GAP.
REQ-027 x_pmem_resp SHALL equal pmem_resp gated by SERVE_x (combinational, same cycle); the other side's resp SHALL be 0.
REQ-028 x_pmem_rdata SHALL pass pmem_rdata through unconditionally; valid only when x_pmem_resp = 1.
REQ-029 GAP lasts exactly one cycle, all commands 0, requests ignored, then IDLE (lets requester deassert after resp).
REQ-030 pmem_resp in IDLE or GAP SHALL be ignored; no state change, no resp forwarded.
REQ-031 Requester deasserting mid-SERVE SHALL NOT abort the transaction; it completes and resp is still pulsed.

Reset
REQ-032 rst high at a clock edge: state IDLE, last_grant I, latched address/wdata 0, all pmem_* commands and both resp outputs 0 from the next cycle.
REQ-033 rst during SERVE_x abandons the transaction; a pmem_resp arriving after reset is ignored per REQ-030.

Verification
REQ-034 I read 0x0000_1000 alone -> pmem_read=1, pmem_address=0x0000_1000 next cycle; pmem_resp with rdata=0xA5.. -> i_pmem_resp=1, i_pmem_rdata=0xA5.., d_pmem_resp=0, then one GAP cycle.
REQ-035 D write 0x0000_2000, wdata=0x1234.. -> pmem_write=1, pmem_read=0, wdata/address match latched values; d_pmem_resp pulses one cycle with pmem_resp.
REQ-036 I and D held high continuously after reset -> grants alternate D, I, D, I; each separated by GAP.
REQ-037 Change d_pmem_address during SERVE_D -> pmem_address unchanged until pmem_resp.
REQ-038 rst asserted mid-SERVE_I, then stray pmem_resp -> state IDLE, i_pmem_resp stays 0, commands 0.
REQ-039 d_pmem_read and d_pmem_write both high -> pmem_write=1, pmem_read=0.

Source files
------------

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between an instruction cache
// and a data cache. One transaction is outstanding at a time; on a conflict
// the grant alternates so neither side starves.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_pmem_*          instruction-cache read-only fill interface
//   d_pmem_*          data-cache fill / write-back interface
//   pmem_*            physical-memory command, address, data and response
module cache_arbiter #(
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_pmem_read,
  input  logic [31:0]          i_pmem_address,
  output logic [LINE_BITS-1:0] i_pmem_rdata,
  output logic                 i_pmem_resp,
  input  logic                 d_pmem_read,
  input  logic                 d_pmem_write,
  input  logic [31:0]          d_pmem_address,
  input  logic [LINE_BITS-1:0] d_pmem_wdata,
  output logic [LINE_BITS-1:0] d_pmem_rdata,
  output logic                 d_pmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    GAP     = 2'd3
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [31:0]          addr_q, addr_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic                 write_q, write_d;

  logic i_req;
  logic d_req;
  logic pick_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;
  // D wins a conflict unless it won the previous grant.
  assign pick_d = d_req & (~i_req | (last_grant_q != GRANT_D));

  // State and latched-transaction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
    end
  end

  // Next-state and grant latching.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          addr_d       = d_pmem_address;
          wdata_d      = d_pmem_wdata;
          // Write takes precedence when both read and write are raised.
          write_d      = d_pmem_write;
        end else if (i_req) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          addr_d       = i_pmem_address;
          wdata_d      = '0;
          write_d      = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: commands only from latched values while serving.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    if (state_q == SERVE_I || state_q == SERVE_D) begin
      pmem_read    = ~write_q;
      pmem_write   = write_q;
      pmem_address = addr_q;
      pmem_wdata   = wdata_q;
    end
    i_pmem_resp = pmem_resp & (state_q == SERVE_I);
    d_pmem_resp = pmem_resp & (state_q == SERVE_D);
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with hand-computed expectations.
module tb_cache_arbiter;
  localparam int unsigned LB = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [31:0]   i_pmem_address;
  logic [LB-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [31:0]   d_pmem_address;
  logic [LB-1:0] d_pmem_wdata;
  logic [LB-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [LB-1:0] pmem_wdata;
  logic [LB-1:0] pmem_rdata;
  logic          pmem_resp;

  int checks = 0;
  int failures = 0;

  cache_arbiter #(.LINE_BITS(LB)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [LB-1:0] rdata_a5;
  logic [LB-1:0] wdata_12;
  logic          exp_d;

  initial begin
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    rdata_a5 = {32{8'hA5}};
    wdata_12 = {16{16'h1234}};

    do_reset();
    check("rst_read", LB'(pmem_read), LB'(0));
    check("rst_write", LB'(pmem_write), LB'(0));
    check("rst_addr", LB'(pmem_address), LB'(0));
    check("rst_iresp", LB'(i_pmem_resp), LB'(0));
    check("rst_dresp", LB'(d_pmem_resp), LB'(0));

    // Stray pmem_resp in IDLE is ignored.
    pmem_resp = 1'b1;
    #1;
    check("idle_iresp", LB'(i_pmem_resp), LB'(0));
    check("idle_dresp", LB'(d_pmem_resp), LB'(0));
    tick();
    pmem_resp = 1'b0;
    check("idle_stay", LB'(pmem_read | pmem_write), LB'(0));

    // Instruction read alone.
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    check("i_not_yet", LB'(pmem_read), LB'(0));
    tick();
    check("i_read", LB'(pmem_read), LB'(1));
    check("i_write", LB'(pmem_write), LB'(0));
    check("i_addr", LB'(pmem_address), LB'(32'h0000_1000));
    i_pmem_read = 1'b0;
    tick();
    check("i_hold", LB'(pmem_read), LB'(1));
    pmem_resp = 1'b1; pmem_rdata = rdata_a5;
    #1;
    check("i_resp", LB'(i_pmem_resp), LB'(1));
    check("i_rdata", i_pmem_rdata, rdata_a5);
    check("i_dresp0", LB'(d_pmem_resp), LB'(0));
    tick();
    check("i_gap_resp", LB'(i_pmem_resp), LB'(0));
    pmem_resp = 1'b0;
    check("i_gap_cmd", LB'(pmem_read | pmem_write), LB'(0));
    tick();

    // Data write with read also raised; address changes mid-transaction.
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_2000; d_pmem_wdata = wdata_12;
    tick();
    check("d_write", LB'(pmem_write), LB'(1));
    check("d_read", LB'(pmem_read), LB'(0));
    check("d_addr", LB'(pmem_address), LB'(32'h0000_2000));
    check("d_wdata", pmem_wdata, wdata_12);
    d_pmem_address = 32'h0000_3000; d_pmem_wdata = '1;
    tick();
    check("d_addr_hold", LB'(pmem_address), LB'(32'h0000_2000));
    check("d_wdata_hold", pmem_wdata, wdata_12);
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    pmem_resp = 1'b1;
    #1;
    check("d_resp", LB'(d_pmem_resp), LB'(1));
    check("d_iresp0", LB'(i_pmem_resp), LB'(0));
    tick();
    pmem_resp = 1'b0;
    #1;
    check("d_resp_pulse", LB'(d_pmem_resp), LB'(0));
    check("d_gap_cmd", LB'(pmem_write), LB'(0));
    tick();

    // Both sides held high from reset: D, I, D, I.
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0200;
    for (int g = 0; g < 4; g++) begin
      exp_d = (g % 2 == 0);
      tick();
      check("alt_read", LB'(pmem_read), LB'(1));
      check("alt_addr", LB'(pmem_address), exp_d ? LB'(32'h0000_0200) : LB'(32'h0000_0100));
      pmem_resp = 1'b1;
      #1;
      check("alt_dresp", LB'(d_pmem_resp), LB'(exp_d));
      check("alt_iresp", LB'(i_pmem_resp), LB'(!exp_d));
      tick();
      pmem_resp = 1'b0;
      check("alt_gap_cmd", LB'(pmem_read | pmem_write), LB'(0));
      tick();
      check("alt_idle_cmd", LB'(pmem_read | pmem_write), LB'(0));
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;

    // Reset during SERVE_I, then stray response.
    tick();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_4000;
    tick();
    i_pmem_read = 1'b0;
    check("rs_serve", LB'(pmem_read), LB'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_cmd", LB'(pmem_read | pmem_write), LB'(0));
    pmem_resp = 1'b1;
    #1;
    check("rs_iresp", LB'(i_pmem_resp), LB'(0));
    tick();
    pmem_resp = 1'b0;
    check("rs_idle", LB'(pmem_read | pmem_write), LB'(0));
    check("rs_addr", LB'(pmem_address), LB'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
